tinker_mem_arbiter: RTL

Single-port memory arbiter for the tinker core. It shares one byte-addressed backing memory between the instruction-fetch requester (32-bit reads) and the data requester (64-bit loads and stores, including call/ret stack traffic). It provides round-robin arbitration, an address range check, a per-transaction timeout and a one-cycle registered response. It sits between the fetch/memory-handler logic and the memory array, and replaces the dual-ported access path.

---
 rtl/tinker_mem_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/tinker_mem_arbiter.sv
// tinker_mem_arbiter: round-robin single-port memory arbiter for fetch (32-bit)
// and data (64-bit) requesters, with range check, timeout and registered response.
`default_nettype none

module tinker_mem_arbiter #(
  parameter int MEM_BYTES = 524288,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        dm_done,
  output logic [63:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_size,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [63:0] C_IF_LIMIT = 64'(MEM_BYTES - 4);
  localparam logic [63:0] C_DM_LIMIT = 64'(MEM_BYTES - 8);
  localparam logic [7:0]  C_TO_LAST  = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_dm;
  logic        r_gnt_dm;
  logic        r_we;
  logic        r_err;
  logic [7:0]  r_tcnt;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;

  logic        w_grant;
  logic        w_pick_dm;
  logic        w_range_err;
  logic        w_timeout;
  logic        w_busy_st;
  logic        w_resp_st;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_pick_dm   = 1'b0;
    w_range_err = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (if_req || dm_req) begin
          w_grant     = 1'b1;
          // On a tie the requester that did not win last time goes first.
          w_pick_dm   = dm_req && (!if_req || !r_last_dm);
          w_range_err = w_pick_dm ? (dm_addr > C_DM_LIMIT) : (if_addr > C_IF_LIMIT);
          w_state_nxt = w_range_err ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        w_timeout = !mem_ack && (r_tcnt == C_TO_LAST);
        if (mem_ack || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_dm <= 1'b1;
      r_gnt_dm  <= 1'b0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_tcnt    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_grant) begin
        r_gnt_dm  <= w_pick_dm;
        r_last_dm <= w_pick_dm;
        r_addr    <= w_pick_dm ? dm_addr : if_addr;
        r_we      <= w_pick_dm & dm_we;
        r_wdata   <= w_pick_dm ? dm_wdata : '0;
        r_err     <= w_range_err;
        r_rdata   <= '0;
        r_tcnt    <= '0;
      end
      if (r_state == S_BUSY) begin
        // Ack wins over a coincident timeout.
        if (mem_ack) begin
          r_err   <= 1'b0;
          r_rdata <= r_we ? 64'd0 : (r_gnt_dm ? mem_rdata : {32'd0, mem_rdata[31:0]});
        end else if (w_timeout) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end else begin
          r_tcnt  <= r_tcnt + 8'd1;
        end
      end
    end
  end

  assign w_busy_st = (r_state == S_BUSY);
  assign w_resp_st = (r_state == S_RESP);

  assign mem_req   = w_busy_st;
  assign mem_we    = w_busy_st & r_we;
  assign mem_size  = w_busy_st & r_gnt_dm;
  assign mem_addr  = w_busy_st ? r_addr : 64'd0;
  assign mem_wdata = w_busy_st ? r_wdata : 64'd0;

  assign if_done   = w_resp_st & !r_gnt_dm;
  assign if_rdata  = if_done ? r_rdata[31:0] : 32'd0;
  assign if_err    = if_done & r_err;
  assign dm_done   = w_resp_st & r_gnt_dm;
  assign dm_rdata  = dm_done ? r_rdata : 64'd0;
  assign dm_err    = dm_done & r_err;

  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
